alu_muldiv: RTL and testbench

Parametrised, registered integer execute unit for the MIPS datapath. It merges the full ALU operation set with an iterative multiply/divide engine, HI/LO registers and a valid/ready handshake on both sides. It sits in the EX stage: decode drives operations in, and the MEM/WB path consumes results. Single-cycle operations return one cycle after acceptance; multiply and divide stall the front end until done.

---
 rtl/alu_muldiv.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_alu_muldiv.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv.sv
// alu_muldiv: registered integer execute unit for the MIPS EX stage.
// Full ALU op set, iterative multiply/divide engine, HI/LO registers and
// valid/ready handshakes on input and output.
// Optional build macro: ALU_FAST_MUL_EN (combinational multiply, no MUL state).
module alu_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_zero,
  output logic             op_err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OpAnd   = 5'h00;
  localparam logic [4:0] OpOr    = 5'h01;
  localparam logic [4:0] OpAdd   = 5'h02;
  localparam logic [4:0] OpSllv  = 5'h03;
  localparam logic [4:0] OpNor   = 5'h04;
  localparam logic [4:0] OpSrlv  = 5'h05;
  localparam logic [4:0] OpSub   = 5'h06;
  localparam logic [4:0] OpSlt   = 5'h07;
  localparam logic [4:0] OpAddu  = 5'h08;
  localparam logic [4:0] OpSubu  = 5'h09;
  localparam logic [4:0] OpXor   = 5'h0A;
  localparam logic [4:0] OpSll   = 5'h0B;
  localparam logic [4:0] OpSrl   = 5'h0C;
  localparam logic [4:0] OpSra   = 5'h0D;
  localparam logic [4:0] OpSrav  = 5'h0E;
  localparam logic [4:0] OpSltu  = 5'h0F;
  localparam logic [4:0] OpMult  = 5'h10;
  localparam logic [4:0] OpMultu = 5'h11;
  localparam logic [4:0] OpDiv   = 5'h12;
  localparam logic [4:0] OpDivu  = 5'h13;
  localparam logic [4:0] OpMfhi  = 5'h14;
  localparam logic [4:0] OpMflo  = 5'h15;
  localparam logic [4:0] OpMthi  = 5'h16;
  localparam logic [4:0] OpMtlo  = 5'h17;

  localparam logic [WIDTH-1:0] MinNeg   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [SHW-1:0]   LastStep = SHW'(WIDTH - 1);

`ifdef ALU_FAST_MUL_EN
  typedef enum logic [2:0] {StIdle, StDiv, StFix, StDone} state_e;
`else
  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;
`endif

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  // Engine state
  logic [2*WIDTH-1:0] prod_q, prod_d;
`ifndef ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
`endif
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               is_mul_q, is_mul_d;
  logic               neg_q, neg_d;     // negate product / quotient at the end
  logic               rneg_q, rneg_d;   // negate remainder at the end
  logic               sp_dz_q, sp_dz_d;
  logic               sp_ovf_q, sp_ovf_d;

  // Front-end combinational signals
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf, alu_err;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fin;
  logic [WIDTH:0]     div_shift, div_trial;

  assign in_ready  = (state_q == StIdle) && (!valid_q || out_ready);
  assign out_valid = valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;
  assign op_err    = err_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  // Single-cycle ALU result and operand magnitudes for the mul/div engine
  always_comb begin
    sum       = data_a + data_b;
    diff      = data_a - data_b;
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_err   = 1'b0;
    is_signed = (op == OpMult) || (op == OpDiv);
    a_neg     = is_signed && data_a[WIDTH-1];
    b_neg     = is_signed && data_b[WIDTH-1];
    a_mag     = a_neg ? ('0 - data_a) : data_a;
    b_mag     = b_neg ? ('0 - data_b) : data_b;
    case (op)
      OpAnd:  alu_res = data_a & data_b;
      OpOr:   alu_res = data_a | data_b;
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (data_a[WIDTH-1] == data_b[WIDTH-1]) && (sum[WIDTH-1] != data_a[WIDTH-1]);
      end
      OpSllv: alu_res = data_b << data_a[SHW-1:0];
      OpNor:  alu_res = ~(data_a | data_b);
      OpSrlv: alu_res = data_b >> data_a[SHW-1:0];
      OpSub: begin
        alu_res = diff;
        alu_ovf = (data_a[WIDTH-1] != data_b[WIDTH-1]) && (diff[WIDTH-1] != data_a[WIDTH-1]);
      end
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(data_a) < $signed(data_b)};
      OpAddu: alu_res = sum;
      OpSubu: alu_res = diff;
      OpXor:  alu_res = data_a ^ data_b;
      OpSll:  alu_res = data_b << shamt;
      OpSrl:  alu_res = data_b >> shamt;
      OpSra:  alu_res = $signed(data_b) >>> shamt;
      OpSrav: alu_res = $signed(data_b) >>> data_a[SHW-1:0];
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, data_a < data_b};
      OpMult, OpMultu, OpDiv, OpDivu: alu_res = '0;
      OpMfhi: alu_res = hi_q;
      OpMflo: alu_res = lo_q;
      OpMthi, OpMtlo: alu_res = data_a;
      default: alu_err = 1'b1;
    endcase
  end

  // FSM next-state, engine datapath and output register loads
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    err_d     = err_q;
    valid_d   = valid_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
`ifndef ALU_FAST_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`endif
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    is_mul_d  = is_mul_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    sp_dz_d   = sp_dz_q;
    sp_ovf_d  = sp_ovf_q;
    prod_fin  = neg_q ? ('0 - prod_q) : prod_q;
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_trial = div_shift - {1'b0, dvsr_q};

    if (valid_q && out_ready) valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          cnt_d    = '0;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          sp_dz_d  = 1'b0;
          sp_ovf_d = 1'b0;
          is_mul_d = 1'b0;
          if (op == OpMult || op == OpMultu) begin
            is_mul_d = 1'b1;
`ifdef ALU_FAST_MUL_EN
            // FIX acts as a register stage for the wide product before the negate
            prod_d   = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
            state_d  = StFix;
`else
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            state_d  = StMul;
`endif
          end else if (op == OpDiv || op == OpDivu) begin
            if (data_b == '0) begin
              sp_dz_d = 1'b1;
              rem_d   = data_a;
              quo_d   = '1;
              state_d = StFix;
            end else if (is_signed && data_a == MinNeg && data_b == '1) begin
              sp_ovf_d = 1'b1;
              rem_d    = '0;
              quo_d    = MinNeg;
              state_d  = StFix;
            end else begin
              rem_d   = '0;
              quo_d   = a_mag;
              dvsr_d  = b_mag;
              state_d = StDiv;
            end
          end else begin
            result_d = alu_res;
            ovf_d    = alu_ovf;
            dz_d     = 1'b0;
            err_d    = alu_err;
            valid_d  = 1'b1;
            if (op == OpMthi) hi_d = data_a;
            if (op == OpMtlo) lo_d = data_a;
          end
        end
      end
`ifndef ALU_FAST_MUL_EN
      StMul: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LastStep) state_d = StDone;
      end
`endif
      StDiv: begin
        // Restoring step: quotient bits shift in from the right as dividend bits leave
        if (!div_trial[WIDTH]) begin
          rem_d = div_trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = div_shift[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastStep) state_d = StFix;
      end
      StFix: begin
        if (!is_mul_q && !sp_dz_q && !sp_ovf_q) begin
          if (neg_q)  quo_d = '0 - quo_q;
          if (rneg_q) rem_d = '0 - rem_q;
        end
        state_d = StDone;
      end
      StDone: begin
        valid_d = 1'b1;
        err_d   = 1'b0;
        if (is_mul_q) begin
          hi_d     = prod_fin[2*WIDTH-1:WIDTH];
          lo_d     = prod_fin[WIDTH-1:0];
          result_d = prod_fin[WIDTH-1:0];
          ovf_d    = 1'b0;
          dz_d     = 1'b0;
        end else begin
          hi_d     = rem_q;
          lo_d     = quo_q;
          result_d = quo_q;
          ovf_d    = sp_ovf_q;
          dz_d     = sp_dz_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      prod_q   <= '0;
`ifndef ALU_FAST_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      is_mul_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      sp_dz_q  <= 1'b0;
      sp_ovf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      prod_q   <= prod_d;
`ifndef ALU_FAST_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      is_mul_q <= is_mul_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      sp_dz_q  <= sp_dz_d;
      sp_ovf_q <= sp_ovf_d;
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: table vectors, hand sequences and random ops against a
// plain-arithmetic reference model of alu_muldiv (WIDTH = 32).
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] data_a, data_b;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow, div_zero, op_err;
  logic [31:0] hi, lo;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .data_a    (data_a),
    .data_b    (data_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .div_zero  (div_zero),
    .op_err    (op_err),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  int errors = 0;
  int checks = 0;

  // Reference model state and expectations
  logic [31:0] m_hi, m_lo, e_r;
  logic        e_ov, e_dz, e_er;
  int          e_lat;

  // Observed values at result time
  logic [31:0] obs_r, obs_hi, obs_lo;
  logic        obs_ov, obs_dz, obs_er;
  int          obs_lat;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [4:0]  sh;
    logic [31:0] r;
    logic        ov, dz, er;
    logic [31:0] hi, lo;
    int          lat;
  } vec_t;

  vec_t vt[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] s);
    longint      sa, sb, t;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e_ov = 1'b0; e_dz = 1'b0; e_er = 1'b0; e_lat = 0; e_r = 32'h0;
    case (o)
      5'h00: e_r = a & b;
      5'h01: e_r = a | b;
      5'h02: begin t = sa + sb; e_r = t[31:0]; e_ov = (t > MaxS) || (t < MinS); end
      5'h03: e_r = b << a[4:0];
      5'h04: e_r = ~(a | b);
      5'h05: e_r = b >> a[4:0];
      5'h06: begin t = sa - sb; e_r = t[31:0]; e_ov = (t > MaxS) || (t < MinS); end
      5'h07: e_r = (sa < sb) ? 32'd1 : 32'd0;
      5'h08: e_r = a + b;
      5'h09: e_r = a - b;
      5'h0A: e_r = a ^ b;
      5'h0B: e_r = b << s;
      5'h0C: e_r = b >> s;
      5'h0D: begin t = sb >>> s; e_r = t[31:0]; end
      5'h0E: begin t = sb >>> a[4:0]; e_r = t[31:0]; end
      5'h0F: e_r = (a < b) ? 32'd1 : 32'd0;
      5'h10: begin t = sa * sb; m_hi = t[63:32]; m_lo = t[31:0]; e_r = m_lo; e_lat = 33; end
      5'h11: begin
        u = {32'h0, a} * {32'h0, b}; m_hi = u[63:32]; m_lo = u[31:0]; e_r = m_lo; e_lat = 33;
      end
      5'h12: begin
        if (b == 32'h0) begin
          e_dz = 1'b1; m_hi = a; m_lo = 32'hFFFF_FFFF; e_lat = 2;
        end else if (sa == MinS && sb == -64'sd1) begin
          e_ov = 1'b1; m_hi = 32'h0; m_lo = a; e_lat = 2;
        end else begin
          t = sa / sb; m_lo = t[31:0];
          t = sa % sb; m_hi = t[31:0];
          e_lat = 34;
        end
        e_r = m_lo;
      end
      5'h13: begin
        if (b == 32'h0) begin
          e_dz = 1'b1; m_hi = a; m_lo = 32'hFFFF_FFFF; e_lat = 2;
        end else begin
          m_lo = a / b; m_hi = a % b; e_lat = 34;
        end
        e_r = m_lo;
      end
      5'h14: e_r = m_hi;
      5'h15: e_r = m_lo;
      5'h16: begin m_hi = a; e_r = a; end
      5'h17: begin m_lo = a; e_r = a; end
      default: e_er = 1'b1;
    endcase
  endfunction

  // Issue one op from idle, wait for its result, compare to the model, then consume it
  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s);
    int lat;
    bit rdy_busy;
    lat = 0;
    while (!in_ready && lat < 200) begin @(posedge clk); #1; lat++; end
    chk($sformatf("op%0h_in_ready", o), in_ready, 1);
    model(o, a, b, s);
    op = o; data_a = a; data_b = b; shamt = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands: the engine must work from captured copies
    data_a = $urandom; data_b = $urandom; shamt = 5'($urandom); op = 5'($urandom);
    lat = 0; rdy_busy = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_busy = 1'b1;
      @(posedge clk); #1; lat++;
    end
    obs_r = result; obs_hi = hi; obs_lo = lo; obs_ov = overflow; obs_dz = div_zero;
    obs_er = op_err; obs_lat = lat;
    chk($sformatf("op%0h_latency", o), lat, e_lat);
    chk($sformatf("op%0h_busy_ready", o), rdy_busy, 0);
    chk($sformatf("op%0h_result", o), result, e_r);
    chk($sformatf("op%0h_overflow", o), overflow, e_ov);
    chk($sformatf("op%0h_div_zero", o), div_zero, e_dz);
    chk($sformatf("op%0h_op_err", o), op_err, e_er);
    chk($sformatf("op%0h_hi", o), hi, m_hi);
    chk($sformatf("op%0h_lo", o), lo, m_lo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk($sformatf("op%0h_valid_drop", o), out_valid, 0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] ed[5];
    ed = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1};
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'($urandom_range(0, 16)) - 32'd8;
      2:       return ed[$urandom_range(0, 4)];
      default: return $urandom & 32'h0000_FFFF;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved;
    bit          stable;
    logic [4:0]  o;

    vt[0]  = '{5'h02, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 0};
    vt[1]  = '{5'h08, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0};
    vt[2]  = '{5'h0D, 32'h0, 32'hF000_0000, 5'd4, 32'hFF00_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0};
    vt[3]  = '{5'h0E, 32'h24, 32'hF000_0000, 5'd0, 32'hFF00_0000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0};
    vt[4]  = '{5'h0F, 32'h1, 32'hFFFF_FFFF, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 0};
    vt[5]  = '{5'h10, 32'hFFFF_FFFD, 32'h5, 5'd0, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
    vt[6]  = '{5'h15, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 0};
    vt[7]  = '{5'h14, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFF1, 0};
    vt[8]  = '{5'h12, 32'hFFFF_FFF9, 32'h2, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vt[9]  = '{5'h12, 32'h5, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0,
               32'h5, 32'hFFFF_FFFF, 2};
    vt[10] = '{5'h12, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0,
               32'h0, 32'h8000_0000, 2};
    vt[11] = '{5'h1F, 32'h1234, 32'h5678, 5'd3, 32'h0, 1'b0, 1'b0, 1'b1,
               32'h0, 32'h8000_0000, 0};
    vt[12] = '{5'h07, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h1, 1'b0, 1'b0, 1'b0,
               32'h0, 32'h8000_0000, 0};
    vt[13] = '{5'h06, 32'h8000_0000, 32'h1, 5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0,
               32'h0, 32'h8000_0000, 0};
    vt[14] = '{5'h16, 32'h1234_5678, 32'h0, 5'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0,
               32'h1234_5678, 32'h8000_0000, 0};
    vt[15] = '{5'h13, 32'h7, 32'h2, 5'd0, 32'h3, 1'b0, 1'b0, 1'b0, 32'h1, 32'h3, 34};
    vt[16] = '{5'h11, 32'hFFFF_FFFF, 32'h2, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0,
               32'h1, 32'hFFFF_FFFE, 33};
    vt[17] = '{5'h0C, 32'h0, 32'hF000_0000, 5'd4, 32'h0F00_0000, 1'b0, 1'b0, 1'b0,
               32'h1, 32'hFFFF_FFFE, 0};
    vt[18] = '{5'h03, 32'h4, 32'h1, 5'd0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h1, 32'hFFFF_FFFE, 0};
    vt[19] = '{5'h12, 32'h7, 32'hFFFF_FFFE, 5'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0,
               32'h1, 32'hFFFF_FFFD, 34};
    vt[20] = '{5'h17, 32'hCAFE_F00D, 32'h0, 5'd0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0,
               32'h1, 32'hCAFE_F00D, 0};

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 5'h0; data_a = 32'h0; data_b = 32'h0; shamt = 5'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_flags", {overflow, div_zero, op_err}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset_in_ready", in_ready, 1);

    // Directed table
    for (int i = 0; i < 21; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sh);
      chk($sformatf("vec%0d_result", i), obs_r, vt[i].r);
      chk($sformatf("vec%0d_flags", i), {obs_ov, obs_dz, obs_er}, {vt[i].ov, vt[i].dz, vt[i].er});
      chk($sformatf("vec%0d_hi", i), obs_hi, vt[i].hi);
      chk($sformatf("vec%0d_lo", i), obs_lo, vt[i].lo);
      chk($sformatf("vec%0d_latency", i), obs_lat, vt[i].lat);
    end

    // Output stall then release with a new op on the same edge
    model(5'h00, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
    op = 5'h00; data_a = 32'hF0F0_1234; data_b = 32'h0FF0_FFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_first_result", result, e_r);
    saved = e_r; stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (!out_valid || result !== saved || in_ready) stable = 1'b0;
    end
    chk("stall_hold", stable, 1);
    model(5'h01, 32'h0000_00F0, 32'h0000_0F00, 5'd0);
    op = 5'h01; data_a = 32'h0000_00F0; data_b = 32'h0000_0F00; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("stall_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("stall_release_valid", out_valid, 1);
    chk("stall_release_result", result, e_r);
    @(posedge clk); #1;
    chk("stall_release_drop", out_valid, 0);
    out_ready = 1'b0;

    // Back-to-back single-cycle ops
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      o = 5'($urandom_range(0, 31));
      if (o >= 5'h10 && o <= 5'h13) o = o + 5'd4;
      op = o; data_a = pick(); data_b = pick(); shamt = 5'($urandom);
      model(op, data_a, data_b, shamt);
      in_valid = 1'b1;
      chk("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
      chk("b2b_valid", out_valid, 1);
      chk($sformatf("b2b_op%0h_result", o), result, e_r);
      chk("b2b_flags", {overflow, div_zero, op_err}, {e_ov, e_dz, e_er});
      chk("b2b_hi", hi, m_hi);
      chk("b2b_lo", lo, m_lo);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", out_valid, 0);
    out_ready = 1'b0;

    // Reset in the middle of a divu
    run_op(5'h16, 32'hDEAD_BEEF, 32'h0, 5'd0);
    op = 5'h13; data_a = 32'd1000; data_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) stable = 1'b0;
    end
    chk("midrst_discarded", stable, 1);
    run_op(5'h1F, 32'h1, 32'h2, 5'd0);
    chk("midrst_err_result", obs_r, 0);
    chk("midrst_err_flag", obs_er, 1);

    // Random ops through the full handshake
    for (int i = 0; i < 150; i++) begin
      run_op(5'($urandom_range(0, 31)), pick(), pick(), 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
